// File: rtl/result_unloader.sv
// result_unloader
//   Reads the 4x4 matrix-multiply result region (N_WORDS words starting at
//   BASE_ADDR) out of a synchronous result RAM and streams it off-chip as a
//   valid/ready word stream, then pulses done.
//
//   Sequence: start -> ordered reads BASE_ADDR..BASE_ADDR+N_WORDS-1
//             -> 2-entry output FIFO -> port_O stream -> done pulse.
//
//   Build option: define RESULT_SATURATE_EN to clamp each ACC_W result
//   (treated as unsigned) to 2**DATA_W-1 instead of truncating it to the
//   low DATA_W bits.
//
// Ports
//   clk          in   single clock, posedge
//   rst          in   asynchronous reset, active low
//   start        in   1-cycle pulse, begins unloading (ignored unless idle)
//   mem_rd_en    out  result RAM read strobe
//   mem_rd_addr  out  result RAM read address
//   mem_rd_data  in   read data, valid the cycle after mem_rd_en
//   port_O       out  output word (FIFO head)
//   out_valid    out  port_O holds a valid word
//   out_ready    in   sink accepts the word at the next posedge
//   out_last     out  high with the final word
//   busy         out  high whenever not idle
//   done         out  1-cycle pulse after the last transfer
module result_unloader #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 16,
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 16,
    parameter int N_WORDS   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [ACC_W-1:0]  mem_rd_data,
    output logic [DATA_W-1:0] port_O,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(N_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_rd_cnt;
    logic                     r_inflight;
    logic                     r_inflight_last;
    logic [1:0][DATA_W-1:0]   r_fifo_data;
    logic [1:0]               r_fifo_last;
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;

    logic                     w_pop;
    logic                     w_push;
    logic                     w_last_issue;
    logic [2:0]               w_used;

    // ACC_W -> DATA_W conversion applied as each word enters the FIFO.
    function automatic logic [DATA_W-1:0] f_convert(input logic [ACC_W-1:0] acc);
`ifdef RESULT_SATURATE_EN
        if (|acc[ACC_W-1:DATA_W])
            return {DATA_W{1'b1}};
        else
            return acc[DATA_W-1:0];
`else
        return acc[DATA_W-1:0];
`endif
    endfunction

    assign out_valid    = (r_count != 2'd0);
    assign port_O       = r_fifo_data[r_rd_ptr];
    assign out_last     = out_valid && r_fifo_last[r_rd_ptr];
    assign w_pop        = out_valid && out_ready;
    assign w_push       = r_inflight;
    assign w_last_issue = (r_rd_cnt == CNT_W'(N_WORDS - 1));
    assign mem_rd_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_rd_cnt);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

    // Credit: FIFO words plus the read in flight, less the word leaving this
    // cycle. Counting the same-cycle pop keeps one read issued per transfer,
    // so the stream sustains one word per cycle with out_ready held high,
    // while never exceeding the two FIFO slots.
    assign w_used = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        mem_rd_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = S_READ;
            end
            S_READ: begin
                mem_rd_en = (w_used < 3'd2);
                if (mem_rd_en && w_last_issue)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && out_last)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_data     <= '0;
            r_fifo_last     <= '0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            // Rewind after each run so the idle address sits at BASE_ADDR.
            if (r_state == S_DONE)
                r_rd_cnt <= '0;
            else if (mem_rd_en)
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);

            r_inflight      <= mem_rd_en;
            r_inflight_last <= mem_rd_en && w_last_issue;

            // The read issued last cycle returns now; capture it with its
            // last-word tag so the tag cannot drift from the data.
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= f_convert(mem_rd_data);
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
module tb_result_unloader;

    localparam int BASE = 16;
    localparam int NW   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mem_rd_en;
    logic [4:0]  mem_rd_addr;
    logic [15:0] mem_rd_data = '0;
    logic [7:0]  port_O;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic        done;

    result_unloader dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .port_O(port_O), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int ram [32];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int idx = 0;          // transfers seen in current run
    int issued = 0;       // reads seen in current run
    int done_cnt = 0;
    int first_valid = -1;
    int done_cyc = -1;
    int last_cyc = -1;
    int ready_mode = 0;
    int rk = 0;
    int got [$];
    bit prev_stall = 0;
    int prev_data = 0;
    int prev_last = 0;

    // Synchronous result RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 16'(ram[mem_rd_addr]);
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected output word for a RAM value.
    function automatic int conv(input int v);
`ifdef RESULT_SATURATE_EN
        return (v > 255) ? 255 : v;
`else
        return v % 256;
`endif
    endfunction

    // Sink ready pattern, updated just after each posedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rk++;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((rk % 3) == 1);
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (rk > 20);
            endcase
        end
    end

    // Compare process: inputs are stable at the falling edge, so a transfer
    // or read seen here happens at the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            idx = 0;
            issued = 0;
            prev_stall = 0;
        end else begin
            if (mem_rd_en) begin
                check("rd_addr", int'(mem_rd_addr), BASE + issued);
                check("rd_count_ok", int'(issued < NW), 1);
                issued++;
            end
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(port_O), prev_data);
                check("hold_last", int'(out_last), prev_last);
            end
            if (out_valid && out_ready) begin
                if (idx < NW) begin
                    check("data", int'(port_O), conv(ram[BASE + idx]));
                    check("last", int'(out_last), int'(idx == NW - 1));
                    got.push_back(int'(port_O));
                    if (idx == NW - 1) last_cyc = cyc;
                end else begin
                    check("extra_xfer", idx, NW - 1);
                end
                idx++;
            end
            check("credit", int'((issued - idx) <= 2), 1);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_after_all", idx, NW);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = int'(port_O);
            prev_last  = int'(out_last);
        end
    end

    task automatic fill_seq();
        for (int i = 0; i < 32; i++) ram[i] = (i >= BASE) ? i - BASE : 16'hDEAD;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++) ram[i] = int'($urandom_range(0, 65535));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One full unload; e0 is the cycle stamp of the falling edge after the
    // edge that sampled start.
    task automatic run(input int mode, input int restart_at, input bit stall_probe,
                       output int e0);
        bit pulsed;
        pulsed = 0;
        ready_mode = mode;
        rk = 0;
        done_cnt = 0;
        first_valid = -1;
        done_cyc = -1;
        last_cyc = -1;
        got.delete();
        idx = 0;
        issued = 0;
        pulse_start();
        @(negedge clk);
        e0 = cyc;
        #2;
        for (int t = 0; t < 800 && done_cnt == 0; t++) begin
            if (stall_probe && t == 12) begin
                check("stall_addr", int'(mem_rd_addr), 18);
                check("stall_rd_en", int'(mem_rd_en), 0);
                check("stall_issued", issued, 2);
            end
            if (restart_at >= 0 && !pulsed && idx >= restart_at) begin
                pulsed = 1;
                check("busy_at_restart", int'(busy), 1);
                pulse_start();
            end
            @(negedge clk);
            #2;
        end
        check("done_seen", done_cnt, 1);
        @(negedge clk);
        check("busy_low", int'(busy), 0);
        repeat (4) @(negedge clk);
        #2;
        check("one_done", done_cnt, 1);
        check("xfers", idx, NW);
        check("got_size", got.size(), NW);
    endtask

    initial begin
        int e0;
        fill_seq();
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(mem_rd_en), 0);
        check("rst_port", int'(port_O), 0);
        check("rst_addr", int'(mem_rd_addr), BASE);
        @(posedge clk); #1 rst = 1'b1;

        // 1: sequential data, ready high, exact timing
        run(0, -1, 0, e0);
        check("lat_valid", first_valid - e0, 2);
        check("lat_last", last_cyc - e0, 17);
        check("lat_done", done_cyc - e0, 18);
        check("pin_first", got[0], 0);
        check("pin_last", got[15], 15);
        check("pin_mid", got[7], 7);

        // 2: ready 1,0,0 pattern
        run(1, -1, 0, e0);
        check("pin2_last", got[15], 15);

        // 3: conversion boundary
        fill_seq();
        ram[16] = 300;
        ram[17] = 255;
        run(0, -1, 0, e0);
`ifdef RESULT_SATURATE_EN
        check("pin_conv300", got[0], 255);
`else
        check("pin_conv300", got[0], 44);
`endif
        check("pin_conv255", got[1], 255);

        // 4: reset after the 5th transfer, then restart from scratch
        fill_rand();
        ready_mode = 0;
        idx = 0;
        issued = 0;
        pulse_start();
        for (int t = 0; t < 200 && idx < 5; t++) begin
            @(negedge clk);
            #2;
        end
        check("pre_abort_idx", idx, 5);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_busy", int'(busy), 0);
            check("abort_valid", int'(out_valid), 0);
            check("abort_addr", int'(mem_rd_addr), BASE);
        end
        @(posedge clk); #1 rst = 1'b1;
        run(0, -1, 0, e0);

        // 5: second start while busy is ignored
        fill_rand();
        run(2, 4, 0, e0);

        // 6: long sink stall right after start
        fill_rand();
        run(3, -1, 1, e0);

        // Extra randomized runs
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run(2, -1, 0, e0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
